// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: shared widths, APB sequencer state codes and AHB transfer codes
package ahb2apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 3;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WWAIT    = 3'd1;
    localparam logic [2:0] READ     = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] WRITEP   = 3'd4;
    localparam logic [2:0] RENABLE  = 3'd5;
    localparam logic [2:0] WENABLE  = 3'd6;
    localparam logic [2:0] WENABLEP = 3'd7;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: APB-side sequencer of the AHB2APB bridge, drives SETUP/ENABLE
// phases from pipelined AHB transfers and stalls AHB via Hreadyout.
import ahb2apb_pkg::*;

module apb_fsm_controller #(
    parameter int ADDR_W = ahb2apb_pkg::ADDR_W,
    parameter int DATA_W = ahb2apb_pkg::DATA_W,
    parameter int SEL_W  = ahb2apb_pkg::SEL_W
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Hwdata1,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [SEL_W-1:0]  tempselx,
    output logic [SEL_W-1:0]  Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout
);

    logic [2:0] state, next_state;
    logic       from_pipe;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:             next_state = valid ? (Hwrite ? WWAIT : READ) : IDLE;
            WWAIT:            next_state = valid ? WRITEP : WRITE;
            READ:             next_state = RENABLE;
            WRITE:            next_state = valid ? WENABLEP : WENABLE;
            WRITEP:           next_state = WENABLEP;
            RENABLE, WENABLE: next_state = valid ? (Hwrite ? WWAIT : READ) : IDLE;
            WENABLEP:         next_state = !Hwritereg ? READ : (valid ? WRITEP : WRITE);
            default:          next_state = IDLE;
        endcase
    end

    // After a pipelined enable the pending write sits one stage deeper in the AHB pipe
    assign from_pipe = (state == WENABLEP);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Hreadyout <= 1'b1;
        end else begin
            case (next_state)
                READ: begin
                    Paddr     <= Haddr;
                    Pwrite    <= 1'b0;
                    Pselx     <= tempselx;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b0;
                end
                WRITE, WRITEP: begin
                    Paddr     <= from_pipe ? Haddr2 : Haddr1;
                    Pwdata    <= from_pipe ? Hwdata1 : Hwdata;
                    Pwrite    <= 1'b1;
                    Pselx     <= tempselx;
                    Penable   <= 1'b0;
                    Hreadyout <= (next_state == WRITE);
                end
                RENABLE, WENABLE, WENABLEP: begin
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
                default: begin
                    Pselx     <= '0;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed scoreboard bench for the APB sequencer
module tb_apb_fsm_controller;

    typedef struct packed {
        logic [2:0]  sel;
        logic        en;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
    } obs_t;

    logic        clk = 1'b0;
    logic        Hresetn = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] Haddr = '0, Haddr1 = '0, Haddr2 = '0;
    logic [31:0] Hwdata = '0, Hwdata1 = '0;
    logic        Hwrite = 1'b0, Hwritereg = 1'b0;
    logic [2:0]  tempselx = '0;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite, Hreadyout;
    logic [31:0] Paddr, Pwdata;

    obs_t q[$];
    obs_t obs;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    apb_fsm_controller dut (
        .Hclk(clk), .Hresetn(Hresetn), .valid(valid),
        .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata(Hwdata), .Hwdata1(Hwdata1),
        .Hwrite(Hwrite), .Hwritereg(Hwritereg), .tempselx(tempselx),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout)
    );

    // Stand-in for the AHB slave pipeline registers
    always @(posedge clk) begin
        Haddr1    <= Haddr;
        Haddr2    <= Haddr1;
        Hwdata1   <= Hwdata;
        Hwritereg <= Hwrite;
    end

    assign obs = {Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout};

    function automatic obs_t x(input logic [2:0] s, input logic e, input logic w,
                               input logic [31:0] a, input logic [31:0] d, input logic r);
        return {s, e, w, a, d, r};
    endfunction

    task automatic check(input string tag);
        obs_t e;
        e = q.pop_front();
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] s, input obs_t e, input string tag);
        valid = v; Hwrite = w; Haddr = a; Hwdata = d; tempselx = s;
        q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        #100;
        q.push_back(x(3'b000, 0, 0, 32'h0, 32'h0, 1));
        check("reset");
        Hresetn = 1'b1;

        cyc(1, 1, 32'h8000_0001, 32'h0,         3'b001, x(3'b000, 0, 0, 32'h0,         32'h0,         1), "wr_wwait");
        cyc(0, 1, 32'h8000_0001, 32'hDEAD_BEEF, 3'b001, x(3'b001, 0, 1, 32'h8000_0001, 32'hDEAD_BEEF, 1), "wr_setup");
        cyc(0, 1, 32'h8000_0001, 32'hDEAD_BEEF, 3'b001, x(3'b001, 1, 1, 32'h8000_0001, 32'hDEAD_BEEF, 1), "wr_enable");
        cyc(0, 1, 32'h8000_0001, 32'hDEAD_BEEF, 3'b001, x(3'b000, 0, 1, 32'h8000_0001, 32'hDEAD_BEEF, 1), "wr_idle");

        cyc(1, 0, 32'h8400_0002, 32'h0, 3'b010, x(3'b010, 0, 0, 32'h8400_0002, 32'hDEAD_BEEF, 0), "rd_setup");
        cyc(0, 0, 32'h8400_0002, 32'h0, 3'b010, x(3'b010, 1, 0, 32'h8400_0002, 32'hDEAD_BEEF, 1), "rd_enable");
        cyc(0, 0, 32'h8400_0002, 32'h0, 3'b010, x(3'b000, 0, 0, 32'h8400_0002, 32'hDEAD_BEEF, 1), "rd_idle");

        cyc(1, 1, 32'h8000_0010, 32'h0,         3'b001, x(3'b000, 0, 0, 32'h8400_0002, 32'hDEAD_BEEF, 1), "b2b_wwait");
        cyc(1, 1, 32'h8000_0014, 32'hCAFE_0010, 3'b001, x(3'b001, 0, 1, 32'h8000_0010, 32'hCAFE_0010, 0), "b2b_writep");
        cyc(0, 1, 32'h8000_0014, 32'hCAFE_0014, 3'b001, x(3'b001, 1, 1, 32'h8000_0010, 32'hCAFE_0010, 1), "b2b_wenablep");
        cyc(0, 1, 32'h8000_0014, 32'hCAFE_0014, 3'b001, x(3'b001, 0, 1, 32'h8000_0014, 32'hCAFE_0014, 1), "b2b_write");
        cyc(0, 1, 32'h8000_0014, 32'hCAFE_0014, 3'b001, x(3'b001, 1, 1, 32'h8000_0014, 32'hCAFE_0014, 1), "b2b_wenable");
        cyc(0, 1, 32'h8000_0014, 32'hCAFE_0014, 3'b001, x(3'b000, 0, 1, 32'h8000_0014, 32'hCAFE_0014, 1), "b2b_idle");

        cyc(0, 1, 32'h9000_0000, 32'h0, 3'b000, x(3'b000, 0, 1, 32'h8000_0014, 32'hCAFE_0014, 1), "oor_idle0");
        cyc(0, 1, 32'h9000_0000, 32'h0, 3'b000, x(3'b000, 0, 1, 32'h8000_0014, 32'hCAFE_0014, 1), "oor_idle1");

        cyc(1, 0, 32'h8400_0008, 32'h0, 3'b010, x(3'b010, 0, 0, 32'h8400_0008, 32'hCAFE_0014, 0), "abort_setup");
        cyc(0, 0, 32'h8400_0008, 32'h0, 3'b010, x(3'b010, 1, 0, 32'h8400_0008, 32'hCAFE_0014, 1), "abort_enable");
        #2;
        Hresetn = 1'b0;
        #1;
        q.push_back(x(3'b000, 0, 0, 32'h0, 32'h0, 1));
        check("abort_async");
        @(negedge clk);
        Hresetn = 1'b1;
        cyc(0, 0, 32'h0, 32'h0, 3'b000, x(3'b000, 0, 0, 32'h0, 32'h0, 1), "abort_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
